// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; a synchronous clear realigns its phase.
module uart_baud_tick #(
    parameter int DIV   = 27,
    parameter int CNT_W = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with oversampled bit recovery.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each bit centre.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 framing_err,
    output logic                 busy,
    output rx_state_t            dbg_state_o
);

    localparam int DIV    = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int BIDX_W = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = OVERSAMPLE / 2 + 1;
`else
    localparam int START_DEC = OVERSAMPLE / 2;
`endif
    localparam logic [TCNT_W-1:0] START_LAST = TCNT_W'(START_DEC - 1);
    localparam logic [TCNT_W-1:0] BIT_LAST   = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] IDX_LAST   = BIDX_W'(DATA_BITS - 1);

    if (DIV < 1 || longint'(DIV) >= (longint'(1) << CNT_W) ||
        (OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_cfg
        $error("uart_rx_core: invalid DIV, CNT_W or OVERSAMPLE");
    end

    logic                 sync1_q, sync2_q, prev_q;
    rx_state_t            state_q, state_d;
    logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
    logic [BIDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 ferr_q, ferr_d, valid_q, valid_d;
    logic                 tick, fall, start_clr, decide, sample_bit;
    logic [TCNT_W-1:0]    tcnt_last;

    uart_baud_tick #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_clr),
        .tick_o (tick)
    );

    // prev_q lags sync2_q, so a fall needs a genuine high->low transition.
    assign fall      = prev_q & ~sync2_q;
    assign tcnt_last = (state_q == START) ? START_LAST : BIT_LAST;
    assign decide    = tick && (state_q != IDLE) && (tcnt_q == tcnt_last);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] maj_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            maj_q <= 2'b11;
        end else if (tick) begin
            maj_q <= {maj_q[0], sync2_q};
        end
    end
    assign sample_bit = (maj_q[1] & maj_q[0]) | (maj_q[1] & sync2_q) | (maj_q[0] & sync2_q);
`else
    assign sample_bit = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (fall) state_d = START;
            START:   if (decide) state_d = sample_bit ? IDLE : DATA;
            DATA:    if (decide && (bit_idx_q == IDX_LAST)) state_d = STOP;
            STOP:    if (decide) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        start_clr   = (state_q == IDLE) && fall;
        dbg_state_o = state_q;
    end

    always_comb begin
        tcnt_d    = tcnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        ferr_d    = ferr_q;
        valid_d   = 1'b0;
        if (start_clr) begin
            tcnt_d    = '0;
            bit_idx_d = '0;
        end else if (decide) begin
            tcnt_d = '0;
        end else if (tick && (state_q != IDLE)) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end
        if (decide && (state_q == DATA)) begin
            shift_d[bit_idx_q] = sample_bit;
            bit_idx_d          = bit_idx_q + BIDX_W'(1);
        end
        if (decide && (state_q == STOP)) begin
            data_d  = shift_q;
            ferr_d  = ~sample_bit;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            tcnt_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            sync1_q   <= rx_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            tcnt_q    <= tcnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
            valid_q   <= valid_d;
        end
    end

    assign data        = data_q;
    assign framing_err = ferr_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frames driven at 434 clocks/bit, results scoreboarded.
module tb_uart_rx_core;

    localparam int BIT_CLKS = 434;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 rx_i = 1'b1;
    logic [7:0]           data;
    logic                 valid;
    logic                 framing_err;
    logic                 busy;
    uart_pkg::rx_state_t  dbg_state;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    logic [8:0] exp_q[$];

    uart_rx_core dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data        (data),
        .valid       (valid),
        .framing_err (framing_err),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: every valid pulse must match the oldest expected {framing_err, data}.
    always @(negedge clk) begin
        logic [8:0] e;
        if (valid === 1'b1) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data=%h ferr=%b, none expected", data, framing_err);
            end else begin
                e = exp_q.pop_front();
                if ({framing_err, data} !== e) begin
                    errors++;
                    $display("FAIL frame: got data=%h ferr=%b, expected data=%h ferr=%b",
                             data, framing_err, e[7:0], e[8]);
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_clks(BIT_CLKS);
        end
        rx_i = stop_bit;
        wait_clks(BIT_CLKS);
        rx_i = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3 * BIT_CLKS) begin
            wait_clks(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d frames still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        rx_i = 1'b1;
        wait_clks(2);
        for (int i = 0; i < 100; i++) begin
            checks++;
            if ({data, valid, framing_err, busy} !== 11'h000) begin
                errors++;
                $display("FAIL reset_outputs: cycle %0d data=%h valid=%b ferr=%b busy=%b, required all 0",
                         i, data, valid, framing_err, busy);
            end
            wait_clks(1);
        end
        rst = 1'b1;
        wait_clks(2 * BIT_CLKS);
    endtask

    task automatic test_single_byte();
        int v0;
        v0 = valid_cnt;
        exp_q.push_back({1'b0, 8'h0F});
        send_frame(8'h0F, 1'b1);
        drain("single");
        checks++;
        if (valid_cnt - v0 != 1) begin
            errors++;
            $display("FAIL single_pulses: got %0d, required 1", valid_cnt - v0);
        end
        checks++;
        if (busy !== 1'b0 || data !== 8'h0F || framing_err !== 1'b0) begin
            errors++;
            $display("FAIL single_hold: busy=%b data=%h ferr=%b, required busy=0 data=0f ferr=0",
                     busy, data, framing_err);
        end
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int v0;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h00;
        bytes[2] = 8'hFF;
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, bytes[i]});
            send_frame(bytes[i], 1'b1);
        end
        drain("b2b");
        checks++;
        if (valid_cnt - v0 != 3) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d, required 3", valid_cnt - v0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: got %b, required 0", busy);
        end
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_framing_error();
        exp_q.push_back({1'b1, 8'h3C});
        send_frame(8'h3C, 1'b0);
        drain("ferr");
        wait_clks(2 * BIT_CLKS);
        checks++;
        if (framing_err !== 1'b1 || data !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_hold: data=%h ferr=%b, required data=3c ferr=1", data, framing_err);
        end
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1);
        drain("ferr_recover");
        checks++;
        if (framing_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clear: got %b, required 0", framing_err);
        end
        wait_clks(BIT_CLKS);
    endtask

    task automatic test_glitch();
        int v0;
        int n;
        logic seen;
        v0   = valid_cnt;
        seen = 1'b0;
        rx_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wait_clks(1);
            if (busy === 1'b1) seen = 1'b1;
        end
        rx_i = 1'b1;
        n = 0;
        while (busy !== 1'b0 && n < 2 * BIT_CLKS) begin
            wait_clks(1);
            n++;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_rise: busy seen=%b, required 1", seen);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy_fall: got %b, required 0", busy);
        end
        wait_clks(BIT_CLKS);
        checks++;
        if (valid_cnt != v0) begin
            errors++;
            $display("FAIL glitch_valid: got %0d pulses, required 0", valid_cnt - v0);
        end
    endtask

    task automatic test_break();
        int v0;
        v0 = valid_cnt;
        exp_q.push_back({1'b1, 8'h00});
        rx_i = 1'b0;
        wait_clks(14 * BIT_CLKS);
        drain("break");
        checks++;
        if (valid_cnt - v0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL break_retrigger: pulses=%0d busy=%b, required pulses=1 busy=0",
                     valid_cnt - v0, busy);
        end
        rx_i = 1'b1;
        wait_clks(2 * BIT_CLKS);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        int v0;
        b  = 8'h5A;
        v0 = valid_cnt;
        rx_i = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_i = b[i];
            wait_clks(BIT_CLKS);
        end
        rx_i = b[4];
        wait_clks(BIT_CLKS / 2);
        rst  = 1'b0;
        rx_i = 1'b1;
        wait_clks(1);
        checks++;
        if ({data, valid, framing_err, busy} !== 11'h000) begin
            errors++;
            $display("FAIL midrst_outputs: data=%h valid=%b ferr=%b busy=%b, required all 0",
                     data, valid, framing_err, busy);
        end
        wait_clks(10);
        rst = 1'b1;
        wait_clks(2 * BIT_CLKS);
        checks++;
        if (valid_cnt != v0) begin
            errors++;
            $display("FAIL midrst_valid: got %0d pulses, required 0", valid_cnt - v0);
        end
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, 1'b1);
        drain("midrst_next");
        checks++;
        if (data !== 8'h81 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next_hold: data=%h busy=%b, required data=81 busy=0", data, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_break();
        test_reset_mid_frame();
        wait_clks(BIT_CLKS);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
